// File: rtl/counter_tick_gen.sv
// Prescaled tick generator with run/stop/burst control feeding the modulus counter enable.
// Build option TICK_SYNC_EN: synchronize and edge-detect the start/stop/burst_go command inputs.
//
// state | meaning
// IDLE  | no ticks, prescaler parked at 0
// RUN   | free-running ticks every div_q+1 cycles
// BURST | ticking until remaining_q reaches zero, then back to IDLE

module counter_tick_gen #(
   parameter int DIV_WIDTH   = 16,
   parameter int DIV_RESET   = 9,
   parameter int BURST_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   burst_go,
   input  logic [BURST_WIDTH-1:0] burst_len,
   input  logic                   div_load,
   input  logic [DIV_WIDTH-1:0]   div_value,
   output logic                   tick,
   output logic                   running,
   output logic [1:0]             state_o,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      BURST = 2'b10
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
   logic                   tick_q, tick_d;
   logic                   done_q, done_d;

   logic cmd_start;
   logic cmd_stop;
   logic cmd_burst;

`ifdef TICK_SYNC_EN
   // bit order: {burst_go, stop, start}; the registered edge pulse gives 3 cycles of latency
   logic [2:0] sync1_q, sync2_q, sync3_q, cmd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         cmd_q   <= '0;
      end else begin
         sync1_q <= {burst_go, stop, start};
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         cmd_q   <= sync2_q & ~sync3_q;
      end
   end

   assign cmd_start = cmd_q[0];
   assign cmd_stop  = cmd_q[1];
   assign cmd_burst = cmd_q[2];
`else
   assign cmd_start = start;
   assign cmd_stop  = stop;
   assign cmd_burst = burst_go;
`endif

   logic active;
   logic terminal;
   logic tick_ok;

   assign active   = (state_q != IDLE);
   assign terminal = (pre_cnt_q == div_q);
   // a divisor load restarts the phase, so it suppresses the tick on its edge
   assign tick_ok  = active && terminal && !div_load;

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      remaining_d = remaining_q;
      div_d       = div_q;
      tick_d      = 1'b0;
      done_d      = 1'b0;

      if (active) begin
         pre_cnt_d = terminal ? '0 : pre_cnt_q + DIV_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (!cmd_stop) begin
               if (cmd_start) begin
                  state_d   = RUN;
                  pre_cnt_d = '0;
               end else if (cmd_burst && (burst_len != '0)) begin
                  state_d     = BURST;
                  remaining_d = burst_len;
                  pre_cnt_d   = '0;
               end
            end
         end
         RUN: begin
            if (cmd_stop) begin
               state_d   = IDLE;
               pre_cnt_d = '0;
            end else begin
               tick_d = tick_ok;
            end
         end
         BURST: begin
            if (cmd_stop) begin
               state_d     = IDLE;
               remaining_d = '0;
               pre_cnt_d   = '0;
            end else if (cmd_start) begin
               state_d     = RUN;
               remaining_d = '0;
               tick_d      = tick_ok;
            end else if (tick_ok) begin
               tick_d = 1'b1;
               if (remaining_q == BURST_WIDTH'(1)) begin
                  done_d      = 1'b1;
                  state_d     = IDLE;
                  remaining_d = '0;
               end else begin
                  remaining_d = remaining_q - BURST_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d     = IDLE;
            pre_cnt_d   = '0;
            remaining_d = '0;
         end
      endcase

      if (div_load) begin
         div_d     = div_value;
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pre_cnt_q   <= '0;
         div_q       <= DIV_WIDTH'(DIV_RESET);
         remaining_q <= '0;
         tick_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         div_q       <= div_d;
         remaining_q <= remaining_d;
         tick_q      <= tick_d;
         done_q      <= done_d;
      end
   end

   assign tick    = tick_q;
   assign done    = done_q;
   assign running = (state_q != IDLE);
   assign state_o = state_q;

endmodule

// File: tb/tb_counter_tick_gen.sv
// Scoreboard bench for counter_tick_gen: expected outputs queued per edge, compared after the edge.

module tb_counter_tick_gen;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_BURST = 2'b10;

   typedef struct packed {
      logic       tick;
      logic       done;
      logic [1:0] st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic        burst_go;
   logic [7:0]  burst_len;
   logic        div_load;
   logic [15:0] div_value;
   logic        tick;
   logic        running;
   logic [1:0]  state_o;
   logic        done;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   counter_tick_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .burst_go  (burst_go),
      .burst_len (burst_len),
      .div_load  (div_load),
      .div_value (div_value),
      .tick      (tick),
      .running   (running),
      .state_o   (state_o),
      .done      (done)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      rst = 0; start = 0; stop = 0; burst_go = 0; burst_len = 0; div_load = 0; div_value = 0;
   endtask

   task automatic test_reset();
      exp_t e, got;
      clear_inputs();
      rst = 1;
      step();
      step();
      e = '{tick: 1'b0, done: 1'b0, st: S_IDLE};
      got = {tick, done, state_o};
      total++;
      if (got !== e || running !== 1'b0) begin
         bad++;
         $display("FAIL reset_values got tick=%b done=%b st=%b run=%b want 0 0 00 0", tick, done, state_o, running);
      end
      rst = 0;
      for (int k = 0; k < 50; k++) begin
         exp_q.push_back('{tick: 1'b0, done: 1'b0, st: S_IDLE});
         step();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e || running !== 1'b0) begin
            bad++;
            $display("FAIL idle k=%0d got tick=%b done=%b st=%b run=%b want %b %b %b 0", k, tick, done, state_o, running, e.tick, e.done, e.st);
         end
      end
   endtask

`ifndef TICK_SYNC_EN
   task automatic test_free_run();
      exp_t e, got;
      for (int k = 0; k <= 40; k++) begin
         start = (k == 0);
         stop  = (k == 25);
         e.tick = (k >= 10 && k < 25 && (k % 10) == 0);
         e.done = 1'b0;
         e.st   = (k < 25) ? S_RUN : S_IDLE;
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e || running !== (e.st != S_IDLE)) begin
            bad++;
            $display("FAIL free_run k=%0d got tick=%b done=%b st=%b run=%b want %b %b %b", k, tick, done, state_o, running, e.tick, e.done, e.st);
         end
      end
   endtask

   task automatic test_div_load();
      exp_t e, got;
      for (int k = 0; k <= 34; k++) begin
         start     = (k == 0);
         stop      = (k == 30);
         div_load  = (k == 5 || k == 15);
         div_value = (k == 15) ? 16'd3 : 16'd0;
         e.tick = (k >= 6 && k <= 14) || (k >= 19 && k < 30 && ((k - 19) % 4) == 0);
         e.done = 1'b0;
         e.st   = (k < 30) ? S_RUN : S_IDLE;
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL div_load k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
   endtask

   task automatic test_burst();
      exp_t e, got;
      for (int k = 0; k <= 16; k++) begin
         div_load  = (k == 0);
         div_value = 16'd2;
         burst_go  = (k == 0);
         burst_len = 8'd4;
         e.tick = (k == 3 || k == 6 || k == 9 || k == 12);
         e.done = (k == 12);
         e.st   = (k < 12) ? S_BURST : S_IDLE;
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL burst4 k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
      for (int k = 0; k < 5; k++) begin
         burst_go  = 1'b1;
         burst_len = 8'd0;
         exp_q.push_back('{tick: 1'b0, done: 1'b0, st: S_IDLE});
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL burst_len0 k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, got;
      for (int k = 0; k <= 16; k++) begin
         burst_go  = (k <= 7);
         burst_len = 8'd2;
         e.tick = (k == 3 || k == 6 || k == 10 || k == 13);
         e.done = (k == 6 || k == 13);
         e.st   = (k <= 5 || (k >= 7 && k <= 12)) ? S_BURST : S_IDLE;
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL retrigger k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
   endtask

   task automatic test_conflicts();
      exp_t e, got;
      for (int k = 0; k < 4; k++) begin
         start = (k == 0);
         stop  = (k == 0);
         exp_q.push_back('{tick: 1'b0, done: 1'b0, st: S_IDLE});
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL start_stop k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
      for (int k = 0; k <= 20; k++) begin
         burst_go  = (k == 0);
         burst_len = 8'd5;
         start     = (k == 7);
         stop      = (k == 17);
         e.tick = (k < 17 && k > 0 && (k % 3) == 0);
         e.done = 1'b0;
         e.st   = (k < 7) ? S_BURST : ((k < 17) ? S_RUN : S_IDLE);
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL burst_to_run k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e, got;
      for (int k = 0; k <= 20; k++) begin
         div_load  = (k == 0);
         div_value = 16'd5;
         burst_go  = (k == 0);
         burst_len = 8'd3;
         rst       = (k == 6);
         start     = (k == 7);
         stop      = (k == 19);
         e.tick = (k == 17);
         e.done = 1'b0;
         e.st   = (k < 6) ? S_BURST : ((k >= 7 && k < 19) ? S_RUN : S_IDLE);
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e || running !== (e.st != S_IDLE)) begin
            bad++;
            $display("FAIL mid_reset k=%0d got tick=%b done=%b st=%b run=%b want %b %b %b", k, tick, done, state_o, running, e.tick, e.done, e.st);
         end
      end
   endtask
`else
   task automatic test_sync();
      exp_t e, got;
      for (int k = 0; k <= 40; k++) begin
         start  = (k < 20) || (k >= 30 && k < 35);
         stop   = (k == 24);
         e.tick = (k == 13 || k == 23);
         e.done = 1'b0;
         e.st   = ((k >= 3 && k <= 26) || k >= 33) ? S_RUN : S_IDLE;
         exp_q.push_back(e);
         step();
         clear_inputs();
         e = exp_q.pop_front();
         got = {tick, done, state_o};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL sync k=%0d got tick=%b done=%b st=%b want %b %b %b", k, tick, done, state_o, e.tick, e.done, e.st);
         end
      end
   endtask
`endif

   initial begin
      clear_inputs();
      @(negedge clk);
      test_reset();
`ifndef TICK_SYNC_EN
      test_free_run();
      test_div_load();
      test_burst();
      test_back_to_back();
      test_conflicts();
      test_mid_reset();
`else
      test_sync();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
